// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: two-digit time-multiplexed driver for a four-digit
// common-anode seven-segment display. Both digits are snapshotted once per
// frame, and each digit slot starts with an all-anodes-off interval to
// suppress ghosting. Segments, anodes and decimal point are active-low.
module ssd_scan_driver #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic       ssd_scan_driver_clk,
    input  logic       ssd_scan_driver_rst,
    input  logic       ssd_scan_driver_en,
    input  logic       ssd_scan_driver_blank_lz,
    input  logic [3:0] ssd_scan_driver_first_num,
    input  logic [3:0] ssd_scan_driver_second_num,
    output logic [6:0] ssd_scan_driver_seg,
    output logic       ssd_scan_driver_dp,
    output logic [3:0] ssd_scan_driver_an
);

    // One counter serves both the blank and the lit part of a slot.
    localparam int unsigned CNT_W      = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned ON_CYCLES  = REFRESH_DIV - BLANK_CYCLES;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic [3:0] AN_ONES = 4'b1110;
    localparam logic [3:0] AN_TENS = 4'b1101;

    typedef enum logic [1:0] {
        BLANK0 = 2'd0,
        ON0    = 2'd1,
        BLANK1 = 2'd2,
        ON1    = 2'd3
    } scanState_t;

    scanState_t       scanState;
    scanState_t       stateNext;
    logic [CNT_W-1:0] slotCnt;
    logic             slotLast;
    logic             snapNow;
    logic [3:0]       lat0;
    logic [3:0]       lat1;
    logic [3:0]       anNext;
    logic [6:0]       segNext;

    // Hex digit to active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hexToSeg(input logic [3:0] digit);
        logic [6:0] pattern;
        pattern = SEG_OFF;
        unique case (digit)
            4'h0: pattern = 7'b1000000;
            4'h1: pattern = 7'b1111001;
            4'h2: pattern = 7'b0100100;
            4'h3: pattern = 7'b0110000;
            4'h4: pattern = 7'b0011001;
            4'h5: pattern = 7'b0010010;
            4'h6: pattern = 7'b0000010;
            4'h7: pattern = 7'b1111000;
            4'h8: pattern = 7'b0000000;
            4'h9: pattern = 7'b0010000;
            4'hA: pattern = 7'b0001000;
            4'hB: pattern = 7'b0000011;
            4'hC: pattern = 7'b1000110;
            4'hD: pattern = 7'b0100001;
            4'hE: pattern = 7'b0000110;
            4'hF: pattern = 7'b0001110;
        endcase
        return pattern;
    endfunction

    // Last count of the current state; blank and lit parts have different lengths.
    always_comb begin
        slotLast = 1'b0;
        if ((scanState == BLANK0) || (scanState == BLANK1)) begin
            slotLast = (slotCnt == BLANK_LAST);
        end else begin
            slotLast = (slotCnt == ON_LAST);
        end
    end

    // Snapshot once per frame, at the very first cycle of BLANK0.
    always_comb begin
        snapNow = (scanState == BLANK0) && (slotCnt == '0);
    end

    // Fixed scan order: BLANK0 -> ON0 -> BLANK1 -> ON1 -> BLANK0.
    always_comb begin
        stateNext = scanState;
        unique case (scanState)
            BLANK0: stateNext = ON0;
            ON0:    stateNext = BLANK1;
            BLANK1: stateNext = ON1;
            ON1:    stateNext = BLANK0;
        endcase
    end

    // Display pattern for the current state; dark whenever scanning is disabled.
    always_comb begin
        anNext  = AN_OFF;
        segNext = SEG_OFF;
        if (ssd_scan_driver_en) begin
            unique case (scanState)
                ON0: begin
                    anNext  = AN_ONES;
                    segNext = hexToSeg(lat0);
                end
                ON1: begin
                    // Leading-zero suppression keeps the tens slot dark but
                    // does not shorten it, so the frame period is unchanged.
                    if (!(ssd_scan_driver_blank_lz && (lat1 == 4'd0))) begin
                        anNext  = AN_TENS;
                        segNext = hexToSeg(lat1);
                    end
                end
                default: begin
                    anNext  = AN_OFF;
                    segNext = SEG_OFF;
                end
            endcase
        end
    end

    // Scan state, slot counter, digit latches and registered outputs.
    always_ff @(posedge ssd_scan_driver_clk) begin
        if (ssd_scan_driver_rst) begin
            scanState           <= BLANK0;
            slotCnt             <= '0;
            lat0                <= 4'd0;
            lat1                <= 4'd0;
            ssd_scan_driver_seg <= SEG_OFF;
            ssd_scan_driver_an  <= AN_OFF;
            ssd_scan_driver_dp  <= 1'b1;
        end else begin
            ssd_scan_driver_seg <= segNext;
            ssd_scan_driver_an  <= anNext;
            ssd_scan_driver_dp  <= 1'b1;
            // With en low everything holds so scanning resumes mid-slot.
            if (ssd_scan_driver_en) begin
                if (snapNow) begin
                    lat0 <= ssd_scan_driver_first_num;
                    lat1 <= ssd_scan_driver_second_num;
                end
                if (slotLast) begin
                    scanState <= stateNext;
                    slotCnt   <= '0;
                end else begin
                    slotCnt <= slotCnt + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Bench for ssd_scan_driver with a short frame (8-cycle slots, 2 blank).
// A frame-position model pushes the expected outputs into a queue as each
// cycle's stimulus is driven; they are popped and checked after the edge.
module tb_ssd_scan_driver;

    localparam int unsigned RD = 8;
    localparam int unsigned BC = 2;
    localparam int unsigned FR = 2 * RD;

    localparam logic [11:0] ALL_OFF = 12'hFFF;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       blz;
    logic [3:0] firstNum;
    logic [3:0] secondNum;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    always #5 clk = ~clk;

    ssd_scan_driver #(
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC)
    ) dut (
        .ssd_scan_driver_clk       (clk),
        .ssd_scan_driver_rst       (rst),
        .ssd_scan_driver_en        (en),
        .ssd_scan_driver_blank_lz  (blz),
        .ssd_scan_driver_first_num (firstNum),
        .ssd_scan_driver_second_num(secondNum),
        .ssd_scan_driver_seg       (seg),
        .ssd_scan_driver_dp        (dp),
        .ssd_scan_driver_an        (an)
    );

    logic [6:0] decTab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic [11:0] expQ [$];
    int total = 0;
    int bad   = 0;

    int unsigned mPos = 0;
    logic [3:0]  mL0  = 4'd0;
    logic [3:0]  mL1  = 4'd0;

    // Drive one cycle: model the output that follows this edge, push it, then check.
    task automatic cyc(input string tag, output logic [11:0] obs);
        logic [10:0] e;
        logic [11:0] expv;
        e = {4'hF, 7'h7F};
        if (rst) begin
            mPos = 0;
            mL0  = 4'd0;
            mL1  = 4'd0;
        end else if (en) begin
            if (mPos == 0) begin
                mL0 = firstNum;
                mL1 = secondNum;
            end
            if (mPos < BC) e = {4'hF, 7'h7F};
            else if (mPos < RD) e = {4'b1110, decTab[mL0]};
            else if (mPos < RD + BC) e = {4'hF, 7'h7F};
            else if (blz && (mL1 == 4'd0)) e = {4'hF, 7'h7F};
            else e = {4'b1101, decTab[mL1]};
            mPos = (mPos + 1) % FR;
        end
        expQ.push_back({e, 1'b1});
        @(posedge clk);
        #1;
        obs  = {an, seg, dp};
        expv = expQ.pop_front();
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // Compare an observation against a hand-written expectation.
    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // Output c cycles after reset release for a frame showing s0 then s1.
    function automatic logic [11:0] lit(input int c, input logic [6:0] s0,
                                        input logic [6:0] s1, input logic dark1);
        int p;
        p = (c - 1) % 16;
        if (p < 2) return ALL_OFF;
        if (p < 8) return {4'b1110, s0, 1'b1};
        if (p < 10) return ALL_OFF;
        if (dark1) return ALL_OFF;
        return {4'b1101, s1, 1'b1};
    endfunction

    initial begin
        logic [11:0] o;
        int guard;

        rst = 1'b1; en = 1'b1; blz = 1'b0; firstNum = 4'd3; secondNum = 4'd7;
        repeat (3) begin
            cyc("reset", o);
            chk("reset_lit", o, ALL_OFF);
        end

        // Basic scan; first changes mid-ON0 and must wait for the next frame.
        rst = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            if (c == 5) firstNum = 4'd9;
            cyc("scan", o);
            chk("scan_lit", o, lit(c, (c <= 16) ? 7'b0110000 : 7'b0010000, 7'b1111000, 1'b0));
        end

        // Leading-zero blanking on, then off.
        firstNum = 4'd5; secondNum = 4'd0; blz = 1'b1;
        for (int c = 1; c <= 32; c++) begin
            cyc("lz_on", o);
            chk("lz_on_lit", o, lit(c, 7'b0010010, 7'b1000000, 1'b1));
        end
        blz = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            cyc("lz_off", o);
            chk("lz_off_lit", o, lit(c, 7'b0010010, 7'b1000000, 1'b0));
        end

        // Hex sweep, one value per frame, tens digit descending.
        blz = 1'b1;
        for (int v = 0; v < 16; v++) begin
            firstNum  = 4'(v);
            secondNum = 4'(15 - v);
            for (int k = 0; k < 16; k++) cyc("hex_sweep", o);
        end

        // Freeze in ON1 at count 3.
        blz = 1'b0; firstNum = 4'd2; secondNum = 4'd8;
        guard = 0;
        while ((mPos != RD + BC + 3) && (guard < 64)) begin
            cyc("to_freeze", o);
            guard++;
        end
        chk("freeze_reached", {11'd0, mPos == RD + BC + 3}, 12'd1);
        en = 1'b0;
        repeat (5) begin
            cyc("freeze", o);
            chk("freeze_lit", o, ALL_OFF);
        end
        en = 1'b1;
        repeat (3) begin
            cyc("resume", o);
            chk("resume_lit", o, {4'b1101, 7'b0000000, 1'b1});
        end
        cyc("resume_end", o);
        chk("resume_end_lit", o, ALL_OFF);

        // Reset mid-ON0 at count 4, then the basic timing again.
        firstNum = 4'd3; secondNum = 4'd7;
        guard = 0;
        while ((mPos != BC + 4) && (guard < 64)) begin
            cyc("to_reset", o);
            guard++;
        end
        chk("reset_reached", {11'd0, mPos == BC + 4}, 12'd1);
        rst = 1'b1;
        cyc("mid_reset", o);
        chk("mid_reset_lit", o, ALL_OFF);
        rst = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            cyc("rescan", o);
            chk("rescan_lit", o, lit(c, 7'b0110000, 7'b1111000, 1'b0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ssd_scan_driver.md
# ssd_scan_driver

Time-multiplexed seven-segment driver that sits directly downstream of the two-digit counter. It takes the ones and tens digits (4-bit, 0x0–0xF) and scans them onto the board's four-digit common-anode display: active-low segments, active-low anodes, and the upper two anodes held dark. Both digits are snapshotted once per frame so the display never tears mid-count. A short all-off interval between digit slots suppresses ghosting.

## Interface
- REFRESH_DIV, 100000: clock cycles per digit slot (1 ms at 100 MHz); must be ≥ 2
- BLANK_CYCLES, 1000: cycles at the start of each slot with all anodes off; must satisfy 0 < BLANK_CYCLES < REFRESH_DIV
- ssd_scan_driver_clk  input  1  system clock; single clock domain
- ssd_scan_driver_rst  input  1  synchronous, active-high reset
- ssd_scan_driver_en  input  1  1 = scan; 0 = freeze scan and blank display
- ssd_scan_driver_blank_lz  input  1  1 = suppress tens digit when it is 0
- ssd_scan_driver_first_num  input  4  ones digit, from the counter's first digit
- ssd_scan_driver_second_num  input  4  tens digit, from the counter's second digit
- ssd_scan_driver_seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- ssd_scan_driver_dp  output  1  decimal point, active-low; constant 1 (off) after reset
- ssd_scan_driver_an  output  4  anodes, active-low; an[0] = ones, an[1] = tens, an[3:2] always 1

## Operation
- FSM states: BLANK0 → ON0 → BLANK1 → ON1 → BLANK0.
- One slot counter, width clog2(REFRESH_DIV), counts 0..len−1 within each state, then clears and advances the state.
  - BLANK length = BLANK_CYCLES.
  - ON length = REFRESH_DIV − BLANK_CYCLES.
- Snapshot: in the cycle where state = BLANK0 and counter = 0, register first_num → lat0 and second_num → lat1.
  - Input changes at any other time are invisible until the next frame.
  - blank_lz is sampled live, not snapshotted.
- Display by state:
  - BLANK0 and BLANK1: an = 4'b1111.
  - ON0: an = 4'b1110, seg = dec(lat0).
  - ON1: an = 4'b1101, seg = dec(lat1). Exception: if blank_lz = 1 and lat1 = 0, then an = 4'b1111.
  - Whenever an = 4'b1111, seg = 7'b1111111.
- Hex decode, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- en = 0: FSM, counter and latches hold; outputs go to an = 1111, seg = 1111111. When en returns to 1, scanning resumes from the held state and count.
- Reset (synchronous) takes priority over en. Reset values:
  - state = BLANK0, counter = 0, lat0 = lat1 = 0
  - seg = 7'b1111111, an = 4'b1111, dp = 1
- Reset asserted mid-slot: all of the above in the next cycle. No partial slot completes.

## Timing
- All outputs are registered: they reflect the state, counter, latches, en and blank_lz of the previous cycle, i.e. one cycle of latency.
- Counter wrap and state change happen in the same cycle. No dead cycle between states.
- Frame period = 2 × REFRESH_DIV cycles exactly, independent of blank_lz.
- First snapshot happens in the first cycle after reset deasserts (state = BLANK0, counter = 0), provided en = 1.
- Input change to visible change:
  - Minimum: an input stable in the snapshot cycle appears on seg BLANK_CYCLES + 1 cycles later (ON0 entry plus output register).
  - Maximum: about 2 × REFRESH_DIV + BLANK_CYCLES + 1 cycles.
- Two anodes are never low in the same cycle. Every anode transition passes through 1111 for ≥ BLANK_CYCLES cycles.

## Test plan
- Reset/basic scan (REFRESH_DIV=8, BLANK_CYCLES=2), inputs first=3, second=7, en=1, blank_lz=0, release reset at cycle 0:
  - cycles 1–2: an=1111, seg=1111111
  - cycles 3–8: an=1110, seg=0110000
  - cycles 9–10: an=1111
  - cycles 11–16: an=1101, seg=1111000
  - the frame then repeats with period 16
- Snapshot isolation: change first from 3 to 9 at cycle 5 (mid-ON0) → ON0 keeps showing 0110000 for this frame; the next frame's ON0 shows 0010000.
- Leading-zero blank: second=0, first=5, blank_lz=1 → ON1 slot shows an=1111, seg=1111111 while ON0 still shows 0010010. With blank_lz=0, ON1 shows an=1101, seg=1000000.
- Full hex sweep: apply first = 0x0..0xF, one value per frame → seg during ON0 matches all 16 decode entries. an[3:2] and dp stay 1 throughout.
- Enable freeze: drop en in ON1 at count 3 for 5 cycles → outputs are 1111/1111111 from the next cycle. After en rises, ON1 completes its remaining 3 counts, then the FSM enters BLANK0.
- Reset mid-slot: assert rst during ON0 at count 4 → the next cycle shows an=1111, seg=1111111, latches 0. After release, timing matches the first scenario.
